// File: rtl/fifo_read_ctrl.sv
// Read-side controller for a flagless FIFO: tracks occupancy by snooping writes,
// issues reads only when data exists and skid room is guaranteed, and reports dropped writes.
module fifo_read_ctrl #(
  parameter int BIT_DEPTH   = 8,
  parameter int FIFO_VOLUME = 8,
  parameter int CNT_W       = $clog2(FIFO_VOLUME + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_wr_en,
  output logic                 fifo_rd_en,
  input  logic [BIT_DEPTH-1:0] fifo_rd_data,
  output logic [BIT_DEPTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     level,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_VOLUME);

  logic [CNT_W-1:0]     level_reg, level_next;
  logic                 overflow_reg, overflow_next;
  logic                 inflight_reg;
  logic [1:0]           skid_count_reg, skid_count_next;
  logic                 head_reg;
  logic [BIT_DEPTH-1:0] skid_mem [2];

  logic       take, pop, push, drop, tail;
  logic [2:0] occ_after_take;

  assign take      = out_valid && out_ready;
  // Words the skid buffer will hold once this cycle's take and the pending capture settle.
  assign occ_after_take = {1'b0, skid_count_reg} + {2'b00, inflight_reg} - {2'b00, take};
  assign pop       = (level_reg != '0) && (occ_after_take < 3'd2);
  assign push      = fifo_wr_en && ((level_reg != FULL_LEVEL) || pop);
  assign drop      = fifo_wr_en && (level_reg == FULL_LEVEL) && !pop;

  // With count==2 the tail slot equals the head slot, which only happens alongside a take.
  assign tail      = head_reg ^ skid_count_reg[0];

  assign fifo_rd_en = pop;
  assign out_data   = skid_mem[head_reg];
  assign out_valid  = (skid_count_reg != 2'd0);
  assign level      = level_reg;
  assign overflow   = overflow_reg;

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (drop)
      overflow_next = 1'b1;
    else if (clr_overflow)
      overflow_next = 1'b0;
  end

  always_comb begin
    skid_count_next = skid_count_reg + {1'b0, inflight_reg} - {1'b0, take};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_reg      <= '0;
      overflow_reg   <= 1'b0;
      inflight_reg   <= 1'b0;
      skid_count_reg <= 2'd0;
      head_reg       <= 1'b0;
      skid_mem[0]    <= '0;
      skid_mem[1]    <= '0;
    end else begin
      level_reg      <= level_next;
      overflow_reg   <= overflow_next;
      inflight_reg   <= pop;
      skid_count_reg <= skid_count_next;
      if (take)
        head_reg <= ~head_reg;
      if (inflight_reg)
        skid_mem[tail] <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural 8-deep FIFO feeding the read port.
module tb_fifo_read_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_wr_en;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] level;
  logic       overflow;
  logic       clr_overflow;
  logic [7:0] wr_data;

  int errors = 0;
  int checks = 0;

  fifo_read_ctrl #(.BIT_DEPTH(8), .FIFO_VOLUME(8)) dut (
    .clk(clk), .rst(rst), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data, writes while full are ignored unless a read coincides.
  logic [7:0] mem_q [$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q.delete();
      fifo_rd_data <= 8'h00;
    end else begin
      if (fifo_rd_en && mem_q.size() > 0)
        fifo_rd_data <= mem_q.pop_front();
      if (fifo_wr_en && (mem_q.size() < 8 || fifo_rd_en))
        mem_q.push_back(wr_data);
    end
  end

  task automatic drive(input logic wr, input logic [7:0] d, input logic rdy, input logic clr);
    fifo_wr_en   = wr;
    wr_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
    #2;
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cyc_end();
    cyc_end();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%0h exp=0", out_data); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%0b exp=0", fifo_rd_en); end
    cyc_end();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || level !== 4'd0) begin
        errors++; $display("FAIL idle_cycle%0d rd_en=%0b valid=%0b level=%0d exp 0/0/0", i, fifo_rd_en, out_valid, level);
      end
      cyc_end();
    end
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    drive(1'b1, 8'd7, 1'b1, 1'b0);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL single_n_rd_en got=%0b exp=0", fifo_rd_en); end
    cyc_end();
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    checks++; if (level !== 4'd1 || fifo_rd_en !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_n1 level=%0d rd_en=%0b valid=%0b exp 1/1/0", level, fifo_rd_en, out_valid);
    end
    cyc_end();
    checks++; if (level !== 4'd0 || fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_n2 level=%0d rd_en=%0b valid=%0b exp 0/0/0", level, fifo_rd_en, out_valid);
    end
    cyc_end();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'd7) begin
      errors++; $display("FAIL single_n3 valid=%0b data=%0d exp 1/7", out_valid, out_data);
    end
    cyc_end();
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL single_n4 valid=%0b level=%0d exp 0/0", out_valid, level);
    end
    $display("test_single_write done");
  endtask

  task automatic test_fill_stalled();
    int rd_pulses = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(9 + i), 1'b0, 1'b0);
      if (fifo_rd_en === 1'b1) rd_pulses++;
      cyc_end();
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    if (fifo_rd_en === 1'b1) rd_pulses++;
    checks++; if (rd_pulses !== 2) begin errors++; $display("FAIL fill_rd_pulses got=%0d exp=2", rd_pulses); end
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL fill_level got=%0d exp=7", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow got=%0b exp=0", overflow); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd9) begin
        errors++; $display("FAIL fill_stall%0d valid=%0b data=%0d exp 1/9", i, out_valid, out_data);
      end
      cyc_end();
      drive(1'b0, 8'd0, 1'b0, 1'b0);
    end
    $display("test_fill_stalled done");
  endtask

  task automatic test_overflow();
    drive(1'b1, 8'd18, 1'b0, 1'b0);
    cyc_end();
    drive(1'b1, 8'd19, 1'b0, 1'b0);
    checks++; if (level !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_full level=%0d overflow=%0b exp 8/0", level, overflow);
    end
    cyc_end();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    checks++; if (level !== 4'd8 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop level=%0d overflow=%0b exp 8/1", level, overflow);
    end
    cyc_end();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_drain();
    logic [7:0] exp_seq [11];
    for (int i = 0; i < 10; i++) exp_seq[i] = 8'(9 + i);
    exp_seq[10] = 8'h55;
    // First cycle: write at full coinciding with a read is accepted.
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL drain_rd_en got=%0b exp=1", fifo_rd_en); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
        errors++; $display("FAIL drain_word%0d valid=%0b data=%0d exp 1/%0d", i, out_valid, out_data, exp_seq[i]);
      end
      cyc_end();
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      if (i == 0) begin
        checks++; if (level !== 4'd8 || overflow !== 1'b0) begin
          errors++; $display("FAIL drain_fullrw level=%0d overflow=%0b exp 8/0", level, overflow);
        end
      end
    end
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL drain_end valid=%0b level=%0d exp 0/0", out_valid, level);
    end
    $display("test_drain done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    int sent = 0;
    int got  = 0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      logic wr;
      wr = (c % 2 == 0) && (sent < 12);
      drive(wr, 8'(8'h30 + sent), logic'(c % 2), 1'b0);
      if (wr) begin exp_q.push_back(8'(8'h30 + sent)); sent++; end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra data=%0h exp none", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin errors++; $display("FAIL stream_word%0d got=%0h exp=%0h", got, out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      cyc_end();
    end
    checks++; if (got !== 12) begin errors++; $display("FAIL stream_count got=%0d exp=12", got); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow got=%0b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      cyc_end();
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      errors++; $display("FAIL prerst valid=%0b data=%0h exp 1/a0", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 4'd0 || fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL async_rst valid=%0b data=%0h level=%0d rd_en=%0b exp 0/0/0/0", out_valid, out_data, level, fifo_rd_en);
    end
    cyc_end();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      checks++; if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL post_rst%0d rd_en=%0b valid=%0b exp 0/0", i, fifo_rd_en, out_valid);
      end
      cyc_end();
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    rst = 1'b1;
    fifo_wr_en = 1'b0; wr_data = 8'h00; out_ready = 1'b0; clr_overflow = 1'b0;
    cyc_end();
    test_reset();
    test_single_write();
    test_fill_stalled();
    test_overflow();
    test_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
